// File: rtl/fft_frame_sched.sv
// fft_frame_sched: paces frame launches into an FFT core with gap and credit.
// Optional result watchdog compiled in by FFT_SCHED_TIMEOUT_EN.
module fft_frame_sched #(
  parameter int FRAMEBITS = 8,
  parameter int GAPBITS   = 16,
  parameter int MAXOUT    = 2,
  parameter int TOBITS    = 20
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RUN,
  input  logic                 ABORT,
  input  logic [FRAMEBITS-1:0] NFRAMES,
  input  logic [GAPBITS-1:0]   GAPLEN,
  input  logic                 IN_EOP,
  input  logic                 OUT_EOP,
  output logic                 FRAME_START,
  output logic [FRAMEBITS-1:0] FRAME_IDX,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR
);

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_LAUNCH = 6'b000010,
    S_WAIT   = 6'b000100,
    S_GAP    = 6'b001000,
    S_DRAIN  = 6'b010000,
    S_FIN    = 6'b100000
  } state_t;

  localparam logic [2:0] MAX_OUT = 3'(MAXOUT);

  state_t               state_q;
  state_t               state_n;
  state_t               state_d;
  logic                 run_q;
  logic                 run_prev_q;
  logic                 armed_q;
  logic [FRAMEBITS-1:0] nfr_q;
  logic [FRAMEBITS-1:0] nfr_d;
  logic [FRAMEBITS-1:0] idx_q;
  logic [FRAMEBITS-1:0] idx_d;
  logic [GAPBITS-1:0]   gap_q;
  logic [GAPBITS-1:0]   gap_d;
  logic [GAPBITS-1:0]   gcnt_q;
  logic [GAPBITS-1:0]   gcnt_d;
  logic [2:0]           out_q;
  logic [2:0]           out_d;
  logic                 err_q;
  logic                 err_d;
  logic                 run_rise;
  logic                 active;
  logic                 launch;
  logic                 kill;
  logic                 wd_fire;

`ifdef FFT_SCHED_TIMEOUT_EN
  localparam logic [TOBITS-1:0] WD_MAX = '1;
  logic [TOBITS-1:0] wd_q;
  logic [TOBITS-1:0] wd_d;
`endif

  // armed_q blocks a RUN level held high through reset from looking like an edge
  assign run_rise = run_q & ~run_prev_q & armed_q;
  assign active   = (state_q != S_IDLE);

  always_comb begin
    state_n = state_q;
    nfr_d   = nfr_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    out_d   = out_q;
    err_d   = err_q;
    launch  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run_rise && !ABORT) begin
          state_n = S_LAUNCH;
          err_d   = 1'b0;
          idx_d   = '0;
          out_d   = '0;
          gcnt_d  = '0;
          nfr_d   = (NFRAMES == '0) ? FRAMEBITS'(1) : NFRAMES;
          gap_d   = GAPLEN;
        end
      end
      S_LAUNCH: begin
        if (out_q < MAX_OUT) begin
          launch  = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (IN_EOP) begin
          if (idx_q == nfr_q - 1'b1) begin
            state_n = S_DRAIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            gcnt_d  = '0;
            state_n = (gap_q == '0) ? S_LAUNCH : S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gcnt_q == gap_q - 1'b1) begin
          state_n = S_LAUNCH;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (out_q == '0) state_n = S_FIN;
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // launch and return in the same cycle cancel out
    if (active) begin
      if (launch && !OUT_EOP) begin
        out_d = out_q + 1'b1;
      end else if (!launch && OUT_EOP) begin
        if (out_q != '0) out_d = out_q - 1'b1;
        else             err_d = 1'b1;
      end
    end

`ifdef FFT_SCHED_TIMEOUT_EN
    wd_d = wd_q;
    if (!active || OUT_EOP || (state_n != state_q)) begin
      wd_d = '0;
    end else if (out_q != '0) begin
      wd_d = wd_q + 1'b1;
    end
    wd_fire = active && !OUT_EOP && (state_n == state_q) &&
              (out_q != '0) && (wd_q == WD_MAX - 1'b1);
`else
    wd_fire = (TOBITS == 0);
`endif

    kill    = active && (ABORT || wd_fire);
    state_d = state_n;
    if (kill) begin
      state_d = S_IDLE;
      out_d   = '0;
      gcnt_d  = '0;
      err_d   = 1'b1;
      launch  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      run_q      <= 1'b0;
      run_prev_q <= 1'b0;
      armed_q    <= 1'b0;
      nfr_q      <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      gcnt_q     <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= RUN;
      run_prev_q <= run_q;
      armed_q    <= armed_q | ~RUN;
      nfr_q      <= nfr_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      gcnt_q     <= gcnt_d;
      out_q      <= out_d;
      err_q      <= err_d;
    end
  end

`ifdef FFT_SCHED_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wd_q <= '0;
    end else begin
      wd_q <= kill ? '0 : wd_d;
    end
  end
`endif

  assign FRAME_START = launch;
  assign FRAME_IDX   = idx_q;
  assign BUSY        = active && (state_q != S_FIN);
  assign DONE        = (state_q == S_FIN) && !kill;
  assign ERR         = err_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
// tb_fft_frame_sched: directed checks of launch pacing, credits, abort, reset.
// Define FFT_SCHED_TIMEOUT_EN on both files to exercise the watchdog.
module tb_fft_frame_sched;

  localparam int FB = 8;
  localparam int GB = 16;
  localparam int MO = 2;
  localparam int TO = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          RUN = 1'b0;
  logic          ABORT = 1'b0;
  logic [FB-1:0] NFRAMES = '0;
  logic [GB-1:0] GAPLEN = '0;
  logic          IN_EOP = 1'b0;
  logic          OUT_EOP = 1'b0;
  logic          FRAME_START;
  logic [FB-1:0] FRAME_IDX;
  logic          BUSY;
  logic          DONE;
  logic          ERR;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int st_c[$];
  int st_i[$];
  int in_c[$];
  int out_c[$];
  int dn_c[$];
  int pend[$];
  int dn;
  int bz;

  fft_frame_sched #(
    .FRAMEBITS(FB),
    .GAPBITS  (GB),
    .MAXOUT   (MO),
    .TOBITS   (TO)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .RUN        (RUN),
    .ABORT      (ABORT),
    .NFRAMES    (NFRAMES),
    .GAPLEN     (GAPLEN),
    .IN_EOP     (IN_EOP),
    .OUT_EOP    (OUT_EOP),
    .FRAME_START(FRAME_START),
    .FRAME_IDX  (FRAME_IDX),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR        (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // leaves the bench in the first LAUNCH cycle of the new run
  task automatic start_run();
    RUN = 1'b0;
    tick();
    RUN = 1'b1;
    tick();
    tick();
  endtask

  task automatic abort_run();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
  endtask

  task automatic watch(input int n, output int d, output int b);
    d = 0;
    b = 0;
    repeat (n) begin
      tick();
      if (DONE) d++;
      if (BUSY) b++;
    end
  endtask

  // IN_EOP in_dly after each launch, OUT_EOP out_dly after each IN_EOP
  task automatic run_sim(input int in_dly, input int out_dly, input int max_cyc);
    int  in_at;
    bit  fin;
    in_at = -1;
    st_c.delete();
    st_i.delete();
    in_c.delete();
    out_c.delete();
    dn_c.delete();
    pend.delete();
    for (int k = 0; k < max_cyc; k++) begin
      fin = 1'b0;
      if (FRAME_START) begin
        st_c.push_back(cyc);
        st_i.push_back(int'(FRAME_IDX));
        in_at = cyc + in_dly;
      end
      if (DONE) begin
        dn_c.push_back(cyc);
        fin = 1'b1;
      end
      IN_EOP  = (cyc == in_at);
      OUT_EOP = (pend.size() > 0) && (pend[0] == cyc);
      if (OUT_EOP) begin
        void'(pend.pop_front());
        out_c.push_back(cyc);
      end
      if (IN_EOP) begin
        in_c.push_back(cyc);
        if (out_dly >= 0) pend.push_back(cyc + out_dly);
      end
      tick();
      if (fin) break;
    end
    IN_EOP  = 1'b0;
    OUT_EOP = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_start", FRAME_START, 0);
    chk("rst_idx", FRAME_IDX, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    RST_N = 1'b1;
    tick();

    // three frames, gap 4, results 20 cycles after each input eop
    NFRAMES = 3;
    GAPLEN  = 4;
    start_run();
    chk("t1_busy", BUSY, 1);
    chk("t1_idx0", FRAME_IDX, 0);
    NFRAMES = 9;
    GAPLEN  = 1;
    run_sim(12, 20, 200);
    chk("t1_starts", st_c.size(), 3);
    chk("t1_idx_a", st_i[0], 0);
    chk("t1_idx_b", st_i[1], 1);
    chk("t1_idx_c", st_i[2], 2);
    chk("t1_gap_a", st_c[1] - in_c[0], 5);
    chk("t1_gap_b", st_c[2] - in_c[1], 5);
    chk("t1_dones", dn_c.size(), 1);
    chk("t1_done_lat", dn_c[0] - out_c[2], 2);
    chk("t1_err", ERR, 0);
    chk("t1_busy_end", BUSY, 0);
    watch(8, dn, bz);
    chk("t1_extra_done", dn, 0);

    // NFRAMES=0 behaves as one frame
    NFRAMES = 0;
    GAPLEN  = 4;
    start_run();
    run_sim(3, 4, 60);
    chk("t2_starts", st_c.size(), 1);
    chk("t2_idx", st_i[0], 0);
    chk("t2_dones", dn_c.size(), 1);
    chk("t2_done_lat", dn_c[0] - out_c[0], 2);
    chk("t2_err", ERR, 0);

    // credit stall with results withheld
    NFRAMES = 4;
    GAPLEN  = 0;
    start_run();
    run_sim(2, -1, 20);
    chk("t3_starts", st_c.size(), 2);
    chk("t3_gap0", st_c[1] - in_c[0], 1);
    chk("t3_stall_start", FRAME_START, 0);
    chk("t3_stall_busy", BUSY, 1);
    chk("t3_stall_idx", FRAME_IDX, 2);
    OUT_EOP = 1'b1;
    tick();
    OUT_EOP = 1'b0;
    chk("t3_credit_start", FRAME_START, 1);
    chk("t3_credit_idx", FRAME_IDX, 2);
    abort_run();
    chk("t3_abort_busy", BUSY, 0);
    chk("t3_abort_err", ERR, 1);

    // abort during the gap before frame 1, then a clean restart
    NFRAMES = 3;
    GAPLEN  = 4;
    start_run();
    chk("t4_err_clr", ERR, 0);
    tick();
    IN_EOP = 1'b1;
    tick();
    IN_EOP = 1'b0;
    chk("t4_gap_idx", FRAME_IDX, 1);
    tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("t4_busy", BUSY, 0);
    chk("t4_err", ERR, 1);
    chk("t4_start", FRAME_START, 0);
    chk("t4_idx_hold", FRAME_IDX, 1);
    watch(8, dn, bz);
    chk("t4_no_done", dn, 0);
    chk("t4_idle", bz, 0);
    start_run();
    chk("t4_re_err", ERR, 0);
    chk("t4_re_idx", FRAME_IDX, 0);
    chk("t4_re_start", FRAME_START, 1);
    abort_run();

    // abort in idle on the same cycle as a run edge wins
    RUN = 1'b0;
    tick();
    RUN = 1'b1;
    tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("t5_busy_a", BUSY, 0);
    chk("t5_err_kept", ERR, 1);
    tick();
    chk("t5_busy_b", BUSY, 0);

    // simultaneous launch and result leaves the count unchanged
    NFRAMES = 2;
    GAPLEN  = 0;
    start_run();
    chk("t6_start0", FRAME_START, 1);
    OUT_EOP = 1'b1;
    tick();
    OUT_EOP = 1'b0;
    chk("t6_err", ERR, 0);
    IN_EOP = 1'b1;
    tick();
    IN_EOP = 1'b0;
    chk("t6_start1", FRAME_START, 1);
    chk("t6_idx1", FRAME_IDX, 1);
    tick();
    IN_EOP = 1'b1;
    tick();
    IN_EOP = 1'b0;
    chk("t6_drain_busy", BUSY, 1);
    chk("t6_drain_done", DONE, 0);
    OUT_EOP = 1'b1;
    tick();
    OUT_EOP = 1'b0;
    chk("t6_zero_done", DONE, 0);
    tick();
    chk("t6_done", DONE, 1);
    chk("t6_done_busy", BUSY, 0);

    // extra result flags an error without underflowing
    NFRAMES = 1;
    start_run();
    tick();
    OUT_EOP = 1'b1;
    tick();
    chk("t7_err_a", ERR, 0);
    tick();
    OUT_EOP = 1'b0;
    chk("t7_err_b", ERR, 1);
    IN_EOP = 1'b1;
    tick();
    IN_EOP = 1'b0;
    chk("t7_drain_done", DONE, 0);
    tick();
    chk("t7_done", DONE, 1);
    tick();
    chk("t7_err_sticky", ERR, 1);

    // reset mid-run with RUN held high
    NFRAMES = 3;
    GAPLEN  = 2;
    start_run();
    tick();
    RST_N = 1'b0;
    #2;
    chk("t8_start", FRAME_START, 0);
    chk("t8_busy", BUSY, 0);
    chk("t8_done", DONE, 0);
    chk("t8_err", ERR, 0);
    chk("t8_idx", FRAME_IDX, 0);
    #1;
    RST_N = 1'b1;
    watch(6, dn, bz);
    chk("t8_no_run", bz, 0);
    chk("t8_no_done", dn, 0);
    start_run();
    chk("t8_re_busy", BUSY, 1);
    chk("t8_re_start", FRAME_START, 1);
    abort_run();

    // results never return
    NFRAMES = 1;
    GAPLEN  = 0;
    start_run();
    tick();
    IN_EOP = 1'b1;
    tick();
    IN_EOP = 1'b0;
    watch(14, dn, bz);
    chk("t9_busy_hold", bz, 14);
    tick();
`ifdef FFT_SCHED_TIMEOUT_EN
    chk("t9_wd_busy", BUSY, 0);
    chk("t9_wd_err", ERR, 1);
    watch(4, dn, bz);
    chk("t9_wd_done", dn, 0);
`else
    chk("t9_busy", BUSY, 1);
    chk("t9_err", ERR, 0);
    abort_run();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_sched.md
FFT_FRAME_SCHED -- requirements
Module: fft_frame_sched

Interface
REQ-001 SHALL have parameter FRAMEBITS, default 8, meaning width of frame-count request and index.
REQ-002 SHALL have parameter GAPBITS, default 16, meaning width of inter-frame gap length in CLK cycles.
REQ-003 SHALL have parameter MAXOUT, default 2, meaning max frames launched but not yet returned by FFT core (1..7).
REQ-004 SHALL have parameter TOBITS, default 20, meaning width of result-watchdog counter.
REQ-005 SHALL have ports, one per line:
  CLK  in  1  sole clock, all logic rising edge
  RST_N  in  1  asynchronous active-low reset
  RUN  in  1  level; rising edge starts a run
  ABORT  in  1  synchronous abort, priority over all else
  NFRAMES  in  FRAMEBITS  frames per run; 0 treated as 1
  GAPLEN  in  GAPBITS  idle cycles between frame launches
  IN_EOP  in  1  input-framer eop pulse (frame fully pushed)
  OUT_EOP  in  1  FFT source eop with source valid (frame result out)
  FRAME_START  out  1  one-cycle pulse to input-framer START
  FRAME_IDX  out  FRAMEBITS  index of frame currently being launched
  BUSY  out  1  high from run accept until DONE
  DONE  out  1  one-cycle pulse, all results returned
  ERR  out  1  sticky error (abort or timeout), cleared at next run accept

Function
REQ-006 SHALL sample RUN into a register and detect rising edge as RUN_reg=1 and previous RUN_reg=0; edges outside IDLE SHALL be ignored.
REQ-007 SHALL latch NFRAMES (0 mapped to 1) and GAPLEN on run accept; input changes mid-run SHALL have no effect.
REQ-008 SHALL implement one-hot states IDLE, LAUNCH, WAIT_IN, GAP, DRAIN, FIN.
REQ-009 IDLE: on accepted edge -> LAUNCH, BUSY=1, ERR=0, FRAME_IDX=0, outstanding count OUTCNT=0.
REQ-010 LAUNCH: if OUTCNT<MAXOUT, assert FRAME_START for exactly one cycle, OUTCNT+1, -> WAIT_IN; else hold (credit stall).
REQ-011 WAIT_IN: on IN_EOP, if FRAME_IDX=NFRAMES-1 -> DRAIN, else FRAME_IDX+1 and -> GAP (GAPLEN=0 -> LAUNCH directly).
REQ-012 GAP: count GAPLEN cycles, then -> LAUNCH; FRAME_START SHALL be launched no earlier than GAPLEN+1 cycles after the IN_EOP cycle.
REQ-013 OUTCNT SHALL decrement on OUT_EOP in any non-IDLE state; simultaneous launch and OUT_EOP SHALL leave OUTCNT unchanged.
REQ-014 OUT_EOP with OUTCNT=0 SHALL be ignored (no underflow) and set ERR.
REQ-015 DRAIN: when OUTCNT=0 -> FIN; FIN asserts DONE one cycle, BUSY=0, -> IDLE.
REQ-016 DONE SHALL occur exactly once per completed run, one cycle after OUTCNT reaches 0 in DRAIN.
REQ-017 ABORT in any non-IDLE state SHALL -> IDLE next cycle, BUSY=0, ERR=1, no DONE, OUTCNT=0, FRAME_START=0.
REQ-018 ABORT in IDLE SHALL have no effect; RUN edge and ABORT same cycle: ABORT wins, run not accepted.
REQ-019 FRAME_IDX SHALL hold its last value after run end until next accept.

Reset
REQ-020 RST_N low SHALL asynchronously force IDLE, FRAME_START=0, FRAME_IDX=0, BUSY=0, DONE=0, ERR=0, OUTCNT=0, gap and watchdog counters 0, RUN history 0.
REQ-021 After RST_N release, RUN already high SHALL NOT start a run; a fresh low-to-high edge is required.
REQ-022 Reset mid-run SHALL discard the run with no DONE pulse.

Configuration
REQ-023 Macro FFT_SCHED_TIMEOUT_EN SHALL compile in a result watchdog.
REQ-024 With FFT_SCHED_TIMEOUT_EN: counter clears on each OUT_EOP and on state entry, counts while OUTCNT>0; on reaching all-ones (2^TOBITS-1) it SHALL act as ABORT (ERR=1, -> IDLE).
REQ-025 Without FFT_SCHED_TIMEOUT_EN: no watchdog logic; DRAIN waits indefinitely; all other behaviour identical.

Verification
REQ-026 NFRAMES=3, GAPLEN=4, MAXOUT=2, OUT_EOP 20 cycles after each IN_EOP -> 3 FRAME_START pulses, FRAME_IDX 0,1,2, each launch 5 cycles after IN_EOP, one DONE after 3rd OUT_EOP, ERR=0.
REQ-027 NFRAMES=4, MAXOUT=2, OUT_EOP withheld -> 2 launches then stall in LAUNCH; first OUT_EOP -> 3rd FRAME_START next cycle.
REQ-028 NFRAMES=0 -> exactly 1 FRAME_START, DONE after its OUT_EOP.
REQ-029 ABORT asserted in GAP of frame 1 -> BUSY=0 next cycle, ERR=1, no DONE; later RUN edge clears ERR and restarts at FRAME_IDX=0.
REQ-030 RST_N pulsed low during WAIT_IN with RUN held high -> all outputs 0, no run until RUN toggles low then high.
REQ-031 With FFT_SCHED_TIMEOUT_EN, TOBITS=4, OUT_EOP never returned -> ERR=1 and IDLE 15 cycles after last counter clear; without macro, BUSY stays 1.
